stack_unit: RTL and testbench
=============================

# stack_unit

Hardware operand stack for the stack-machine datapath, sitting directly downstream of the multicycle controller. It consumes the controller's push and pop strobes plus the write-data mux output, holds the operand stack in registers, and returns the current top-of-stack value and the zero-test flag (`nor_top`) that the controller uses for conditional jumps.

## Interface
- `WIDTH`, 8: data width of each stack entry.
- `DEPTH`, 8: number of entries; must be a power of two ≥ 2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `push`  in  1  push `din` this cycle.
- `pop`  in  1  pop the top entry this cycle.
- `din`  in  WIDTH  data to push (ALU result or memory read data, selected upstream).
- `top`  out  WIDTH  current top entry; 0 when empty.
- `nor_top`  out  1  1 when `top` == 0, including when empty.
- `count`  out  $clog2(DEPTH+1)  number of valid entries.
- `full`  out  1  `count` == DEPTH.
- `empty`  out  1  `count` == 0.
- `overflow`  out  1  sticky error flag (see Configuration).
- `underflow`  out  1  sticky error flag (see Configuration).

## Operation
- State consists of entry storage `mem[0..DEPTH-1]` and the stack pointer `sp` (equal to `count`). The top entry is `mem[sp-1]`.
- Each cycle, the op is decoded from {push, pop}:
  - NOP 00: no change.
  - PUSH 10: if not full, write `mem[sp]` ← `din` and increment `sp`. If full, storage is unchanged and the overflow event is raised.
  - POP 01: if not empty, decrement `sp`; storage is unchanged. If empty, there is no change and the underflow event is raised.
  - REPL 11: if not empty, write `mem[sp-1]` ← `din` and leave `sp` unchanged. This applies even when full, and no overflow is raised. If empty, the op behaves as PUSH and no underflow is raised.
- `top`, `nor_top`, `full`, `empty` and `count` are combinational from registered state only. They never depend on `push`, `pop` or `din` in the same cycle.
- `count` never exceeds DEPTH and never wraps below 0.
- Reset effects:
  - Reset clears `sp`, `overflow` and `underflow`. Storage is not cleared; its contents are don't-care.
  - After reset: `top`=0, `nor_top`=1, `empty`=1, `full`=0, `count`=0, `overflow`=0, `underflow`=0.
  - Reset asserted mid-sequence takes effect immediately and overrides any op in flight.

## Timing
- Zero-latency read: the value presented on `top` before an edge is the value being popped. The controller latches X/Y from `top` in the same cycle it asserts `pop`.
- A push or replace is visible on `top` and `nor_top` from the edge that performs it (one-cycle write-to-read).
- `full`, `empty` and `count` update on the same edge as `sp`.
- Overflow and underflow flags set on the edge following the offending cycle. They remain set until reset.

## Configuration
- `STACK_ERR_EN` defined: the `overflow` and `underflow` sticky registers are implemented as described above.
- `STACK_ERR_EN` undefined:
  - Both outputs are tied to 0 and no flag registers exist.
  - Illegal ops are still ignored; the storage and `sp` behaviour is identical either way.

## Structure
- Package `stack_pkg` holds:
  - default constants `STACK_WIDTH`=8 and `STACK_DEPTH`=8;
  - `typedef enum logic [1:0] {ST_NOP, ST_POP, ST_PUSH, ST_REPL} stack_op_t`, encoded as {push, pop}.
- Sub-module `stack_regfile`: DEPTH×WIDTH register array with one synchronous write port (we, waddr, wdata) and one asynchronous read port (raddr, rdata). It has no reset.
- `stack_unit` contains the op decode, the `sp` counter, the flag registers and the output logic.

## Test plan
All scenarios use WIDTH=8 and DEPTH=4.
- Reset, then idle → `top`=0, `nor_top`=1, `empty`=1, `count`=0, flags 0.
- Push 0x05, 0x00, 0x09 → `top` sequence 0x05, 0x00, 0x09; `nor_top` 0, 1, 0; `count`=3. Then pop twice → `top` 0x00 (`nor_top`=1), then 0x05.
- Push 4 values (0x11..0x14), then push 0x55 → `full`=1, `top`=0x14, `count`=4, `overflow`=1 (`STACK_ERR_EN` build). Then REPL with 0x77 → `top`=0x77, `count`=4.
- Pop when empty → `count` stays 0, `top`=0, `underflow`=1. Rebuild without `STACK_ERR_EN` → `underflow` stays 0 and state is identical.
- Single-cycle ALU step: stack holds [0x03, 0x04], pop with `top`=0x04 sampled, pop with 0x03 sampled, push 0x07 → `count`=1, `top`=0x07.
- Assert `rst` mid-push while `count`=2 → on assertion `count`=0, `empty`=1, `top`=0, flags cleared; the next push of 0x2A yields `top`=0x2A, `count`=1.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared constants and op encoding for the operand stack.
package stack_pkg;

    localparam int STACK_WIDTH = 8;
    localparam int STACK_DEPTH = 8;

    // Encoded as {push, pop}
    typedef enum logic [1:0] {
        ST_NOP  = 2'b00,
        ST_POP  = 2'b01,
        ST_PUSH = 2'b10,
        ST_REPL = 2'b11
    } stack_op_t;

endpackage

// File: rtl/stack_unit_if.sv
// Controller-to-stack bus: push/pop strobes and write data in, top-of-stack and status out.
interface stack_unit_if
    import stack_pkg::*;
#(
    parameter int WIDTH = STACK_WIDTH,
    parameter int DEPTH = STACK_DEPTH
) ();

    localparam int CW = $clog2(DEPTH + 1);

    logic             push;
    logic             pop;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] top;
    logic             nor_top;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
    logic             overflow;
    logic             underflow;

    modport master (
        output push, pop, din,
        input  top, nor_top, count, full, empty, overflow, underflow
    );

    modport slave (
        input  push, pop, din,
        output top, nor_top, count, full, empty, overflow, underflow
    );

endinterface

// File: rtl/stack_unit_regfile.sv
// Stack entry storage: one synchronous write port, one asynchronous read port, no reset.
module stack_regfile
    import stack_pkg::*;
#(
    parameter int WIDTH = STACK_WIDTH,
    parameter int DEPTH = STACK_DEPTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/stack_unit.sv
// Operand stack: op decode, stack pointer, sticky error flags and top-of-stack outputs.
// Build option: define STACK_ERR_EN to implement the sticky overflow/underflow flags.
module stack_unit
    import stack_pkg::*;
#(
    parameter int WIDTH = STACK_WIDTH,
    parameter int DEPTH = STACK_DEPTH
) (
    input  logic         clk,
    input  logic         rst,
    stack_unit_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    stack_op_t        op;
    logic [CW-1:0]    sp;
    logic [CW-1:0]    sp_next;
    logic [CW-1:0]    sp_dec;
    logic             is_full;
    logic             is_empty;
    logic             we;
    logic [AW-1:0]    waddr;
    logic [AW-1:0]    raddr;
    logic [WIDTH-1:0] rdata;

    assign op       = stack_op_t'({bus.push, bus.pop});
    assign is_full  = (sp == CW'(DEPTH));
    assign is_empty = (sp == '0);
    assign sp_dec   = sp - CW'(1);

    always_comb begin
        we      = 1'b0;
        waddr   = sp[AW-1:0];
        sp_next = sp;
        case (op)
            ST_PUSH: begin
                if (!is_full) begin
                    we      = 1'b1;
                    sp_next = sp + CW'(1);
                end
            end
            ST_POP: begin
                if (!is_empty) begin
                    sp_next = sp_dec;
                end
            end
            ST_REPL: begin
                // Replace on an empty stack degenerates to a plain push
                we = 1'b1;
                if (is_empty) begin
                    sp_next = sp + CW'(1);
                end else begin
                    waddr = sp_dec[AW-1:0];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp <= '0;
        end else begin
            sp <= sp_next;
        end
    end

    stack_regfile #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_regfile (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (bus.din),
        .raddr (raddr),
        .rdata (rdata)
    );

    assign raddr       = sp_dec[AW-1:0];
    assign bus.top     = is_empty ? '0 : rdata;
    assign bus.nor_top = (bus.top == '0);
    assign bus.count   = sp;
    assign bus.full    = is_full;
    assign bus.empty   = is_empty;

`ifdef STACK_ERR_EN
    logic ovf_q;
    logic unf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (op == ST_PUSH && is_full) begin
                ovf_q <= 1'b1;
            end
            if (op == ST_POP && is_empty) begin
                unf_q <= 1'b1;
            end
        end
    end

    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
`else
    assign bus.overflow  = 1'b0;
    assign bus.underflow = 1'b0;
`endif

endmodule

// File: tb/tb_stack_unit.sv
// Directed scoreboard bench for stack_unit with WIDTH=8, DEPTH=4.
module tb_stack_unit;

`ifdef STACK_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    localparam int DEPTH = 4;

    typedef struct {
        logic [7:0] top;
        logic       nor_top;
        logic [2:0] count;
        logic       full;
        logic       empty;
        logic       ovf;
        logic       unf;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    exp_t       sbq  [$];
    logic [7:0] mstk [$];
    bit         mov;
    bit         mun;

    stack_unit_if #(.WIDTH(8), .DEPTH(DEPTH)) bus ();

    stack_unit #(.WIDTH(8), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mstk.delete();
        mov = 1'b0;
        mun = 1'b0;
    endtask

    task automatic model_op(input bit p, input bit q, input logic [7:0] d);
        case ({p, q})
            2'b10: if (mstk.size() < DEPTH) mstk.push_back(d); else if (ERR_EN) mov = 1'b1;
            2'b01: if (mstk.size() > 0) void'(mstk.pop_back()); else if (ERR_EN) mun = 1'b1;
            2'b11: if (mstk.size() == 0) mstk.push_back(d); else mstk[mstk.size()-1] = d;
            default: ;
        endcase
    endtask

    task automatic expect_now();
        exp_t e;
        e.top     = (mstk.size() > 0) ? mstk[mstk.size()-1] : 8'h00;
        e.nor_top = (e.top == 8'h00);
        e.count   = 3'(mstk.size());
        e.full    = (mstk.size() == DEPTH);
        e.empty   = (mstk.size() == 0);
        e.ovf     = mov;
        e.unf     = mun;
        sbq.push_back(e);
    endtask

    task automatic check_state(input string tag);
        exp_t e;
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: scoreboard empty, got nothing expected an entry", tag);
            return;
        end
        e = sbq.pop_front();
        chk({tag, ".top"},       bus.top,       e.top);
        chk({tag, ".nor_top"},   bus.nor_top,   e.nor_top);
        chk({tag, ".count"},     bus.count,     e.count);
        chk({tag, ".full"},      bus.full,      e.full);
        chk({tag, ".empty"},     bus.empty,     e.empty);
        chk({tag, ".overflow"},  bus.overflow,  e.ovf);
        chk({tag, ".underflow"}, bus.underflow, e.unf);
    endtask

    // Called at a negedge; returns at the following negedge with strobes idle
    task automatic step(input bit p, input bit q, input logic [7:0] d, input string tag);
        bus.push = p;
        bus.pop  = q;
        bus.din  = d;
        model_op(p, q, d);
        expect_now();
        @(posedge clk);
        #1;
        check_state(tag);
        @(negedge clk);
        bus.push = 1'b0;
        bus.pop  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        bus.din  = 8'h00;
        model_reset();
        do_reset();

        expect_now();
        check_state("reset");
        step(1'b0, 1'b0, 8'hAA, "idle");

        step(1'b1, 1'b0, 8'h05, "push05");
        step(1'b1, 1'b0, 8'h00, "push00");
        step(1'b1, 1'b0, 8'h09, "push09");
        step(1'b0, 1'b1, 8'h00, "pop1");
        step(1'b0, 1'b1, 8'h00, "pop2");
        step(1'b0, 1'b1, 8'h00, "pop3");

        step(1'b0, 1'b1, 8'h00, "pop_empty");
        step(1'b0, 1'b0, 8'h00, "after_underflow");

        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 8'h11 + 8'(i), $sformatf("fill%0d", i));
        end
        step(1'b1, 1'b0, 8'h55, "push_full");
        step(1'b1, 1'b1, 8'h77, "repl_full");
        step(1'b0, 1'b1, 8'h00, "pop_after_repl");

        do_reset();
        expect_now();
        check_state("reset2");
        step(1'b1, 1'b1, 8'h3C, "repl_empty");
        step(1'b0, 1'b1, 8'h00, "pop_repl_empty");

        step(1'b1, 1'b0, 8'h03, "alu_push03");
        step(1'b1, 1'b0, 8'h04, "alu_push04");
        chk("alu_x_sample", bus.top, 8'h04);
        step(1'b0, 1'b1, 8'h00, "alu_popx");
        chk("alu_y_sample", bus.top, 8'h03);
        step(1'b0, 1'b1, 8'h00, "alu_popy");
        step(1'b1, 1'b0, 8'h07, "alu_push07");

        step(1'b1, 1'b0, 8'h2B, "pre_rst_push");
        bus.push = 1'b1;
        bus.din  = 8'h33;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        expect_now();
        check_state("rst_async");
        @(posedge clk);
        #1;
        expect_now();
        check_state("rst_hold");
        @(negedge clk);
        rst      = 1'b0;
        bus.push = 1'b0;
        step(1'b1, 1'b0, 8'h2A, "push2A");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
